// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the HI/LO multiply/divide unit.
// Imported by muldiv_unit and the hazard unit.
package muldiv_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Callers size-cast in and out; low bits are exact for any width.
  function automatic logic [MAX_W-1:0] twos_neg(
    input logic [MAX_W-1:0] x
  );
    return ~x + MAX_W'(1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between EX stage and the mul/div unit.
// master = EX/decoder side, slave = muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_div, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_div, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One shift-add (MULT) or restoring-subtract (DIV) iteration.
// work = {upper, lower}; shreg = multiplier or dividend.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] work,
  input  logic [WIDTH-1:0]   opnd,
  input  logic [WIDTH-1:0]   shreg,
  output logic [2*WIDTH-1:0] work_nxt,
  output logic [WIDTH-1:0]   shreg_nxt
);

  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    acc = {1'b0, work[2*WIDTH-1:WIDTH]}
        + {1'b0, (shreg[0] ? opnd : '0)};
    rem_sh = {work[2*WIDTH-1:WIDTH], shreg[WIDTH-1]};
    diff = rem_sh[WIDTH-1:0] - opnd;
    if (is_div == OP_DIV) begin
      if (rem_sh >= {1'b0, opnd}) begin
        work_nxt = {diff, work[WIDTH-2:0], 1'b1};
      end else begin
        work_nxt = {rem_sh[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
      end
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      work_nxt = {acc, work[WIDTH-1:1]};
      shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed MULT/DIV owning the HI/LO pair.
// WIDTH iterations on magnitudes, sign fix-up on the last one.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  muldiv_state_t state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             b_zero_q, b_zero_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [W2-1:0]    work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [W2-1:0]    work_nxt;
  logic [WIDTH-1:0] shreg_nxt;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] quot, rem;
  logic             neg_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_q),
    .work      (work_q),
    .opnd      (opnd_q),
    .shreg     (shreg_q),
    .work_nxt  (work_nxt),
    .shreg_nxt (shreg_nxt)
  );

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    b_zero_d = b_zero_q;
    opnd_d   = opnd_q;
    shreg_d  = shreg_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    abs_a = bus.a[WIDTH-1]
          ? WIDTH'(twos_neg(MAX_W'(bus.a))) : bus.a;
    abs_b = bus.b[WIDTH-1]
          ? WIDTH'(twos_neg(MAX_W'(bus.b))) : bus.b;
    neg_res = sign_a_q ^ sign_b_q;
    quot = work_nxt[WIDTH-1:0];
    rem  = work_nxt[W2-1:WIDTH];
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          is_div_d = bus.is_div;
          sign_a_d = bus.a[WIDTH-1];
          sign_b_d = bus.b[WIDTH-1];
          b_zero_d = (bus.b == '0);
          work_d   = '0;
          cnt_d    = CW'(WIDTH - 1);
          opnd_d   = bus.is_div ? abs_b : abs_a;
          shreg_d  = bus.is_div ? abs_a : abs_b;
        end
      end
      RUN: begin
        work_d  = work_nxt;
        shreg_d = shreg_nxt;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          if (is_div_q == OP_DIV) begin
            // Divide by zero reports all-ones quotient whatever the sign.
            lo_d = b_zero_q ? '1
                 : neg_res ? WIDTH'(twos_neg(MAX_W'(quot))) : quot;
            hi_d = sign_a_q
                 ? WIDTH'(twos_neg(MAX_W'(rem))) : rem;
          end else begin
            {hi_d, lo_d} = neg_res
                         ? W2'(twos_neg(MAX_W'(work_nxt)))
                         : work_nxt;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      b_zero_q <= 1'b0;
      opnd_q   <= '0;
      shreg_q  <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      b_zero_q <= b_zero_d;
      opnd_q   <= opnd_d;
      shreg_q  <= shreg_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against a plain
// signed-arithmetic model of HI/LO.
module tb_muldiv_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Returns {hi, lo} from ordinary signed arithmetic.
  function automatic logic [63:0] model(
    input logic op, input logic [31:0] a, input logic [31:0] b
  );
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 1'b0) return 64'(sa * sb);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and observes it until busy drops.
  task automatic run_op(
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          busy_cyc,
    output int          done_edge,
    output int          done_cnt,
    output bit          to
  );
    bus.start = 1'b1;
    bus.is_div = op;
    bus.a = a;
    bus.b = b;
    tick();
    bus.start = 1'b0;
    bus.is_div = 1'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    busy_cyc = 0;
    done_edge = -1;
    done_cnt = 0;
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) tick();
      if (bus.done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
      if (!bus.busy) begin
        to = 1'b0;
        break;
      end
      busy_cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.is_div = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h expected 0_0",
               bus.hi, bus.lo);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic        ops [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] as  [5] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFF9,
                             32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd2,
                             32'hFFFF_FFFF, 32'd0};
    logic [63:0] exp;
    int bc, de, dc;
    bit to;
    for (int i = 0; i < 5; i++) begin
      exp = model(ops[i], as[i], bs[i]);
      run_op(ops[i], as[i], bs[i], bc, de, dc, to);
      checks++;
      if (to || bc != WIDTH + 1) begin
        errors++;
        $display("FAIL dir%0d_busy_cycles: got %0d expected %0d",
                 i, bc, WIDTH + 1);
      end
      checks++;
      if (de != WIDTH || dc != 1) begin
        errors++;
        $display("FAIL dir%0d_done: edge %0d count %0d expected %0d 1",
                 i, de, dc, WIDTH);
      end
      checks++;
      if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
        errors++;
        $display("FAIL dir%0d_hilo: got %h_%h expected %h_%h",
                 i, bus.hi, bus.lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_random();
    logic        op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int bc, de, dc;
    bit to;
    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom);
      a = pick_opnd();
      b = pick_opnd();
      exp = model(op, a, b);
      run_op(op, a, b, bc, de, dc, to);
      checks++;
      if (to || de != WIDTH || dc != 1) begin
        errors++;
        $display("FAIL rnd%0d_timing: edge %0d count %0d expected %0d 1",
                 i, de, dc, WIDTH);
      end
      checks++;
      if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
        errors++;
        $display("FAIL rnd%0d_hilo op=%b a=%h b=%h: got %h_%h expected %h_%h",
                 i, op, a, b, bus.hi, bus.lo, exp[63:32], exp[31:0]);
      end
      repeat ($urandom_range(1, 4)) begin
        bus.a = $urandom;
        bus.b = $urandom;
        bus.is_div = 1'($urandom);
        tick();
      end
      checks++;
      if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
        errors++;
        $display("FAIL rnd%0d_hold: got %h_%h expected %h_%h",
                 i, bus.hi, bus.lo, exp[63:32], exp[31:0]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] exp;
    int dc, de, bc, dc2;
    bit to;
    a1 = $urandom;
    b1 = $urandom;
    exp = model(1'b0, a1, b1);
    bus.start = 1'b1;
    bus.is_div = 1'b0;
    bus.a = a1;
    bus.b = b1;
    tick();
    dc = 0;
    de = -1;
    for (int k = 1; k <= WIDTH + 1; k++) begin
      bus.start = (k == 5 || k == WIDTH + 1);
      bus.is_div = 1'b1;
      bus.a = $urandom;
      bus.b = $urandom | 32'd1;
      tick();
      if (bus.done) begin
        dc++;
        de = k;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_busy_after_done: got %b expected 0", bus.busy);
    end
    checks++;
    if (dc != 1 || de != WIDTH) begin
      errors++;
      $display("FAIL ign_done: edge %0d count %0d expected %0d 1",
               de, dc, WIDTH);
    end
    checks++;
    if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL ign_hilo: got %h_%h expected %h_%h",
               bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
    a2 = $urandom;
    b2 = 32'($urandom_range(1, 1000));
    exp = model(1'b1, a2, b2);
    run_op(1'b1, a2, b2, bc, de, dc2, to);
    checks++;
    if (to || bc != WIDTH + 1 || de != WIDTH || dc2 != 1) begin
      errors++;
      $display("FAIL b2b_timing: busy %0d edge %0d count %0d expected %0d %0d 1",
               bc, de, dc2, WIDTH + 1, WIDTH);
    end
    checks++;
    if (bus.hi !== exp[63:32] || bus.lo !== exp[31:0]) begin
      errors++;
      $display("FAIL b2b_hilo: got %h_%h expected %h_%h",
               bus.hi, bus.lo, exp[63:32], exp[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    int bc, de, dc, late_done, late_busy;
    bit to;
    run_op(1'b0, 32'd1234, 32'd5678, bc, de, dc, to);
    checks++;
    if (bus.lo !== 32'd7006652 || bus.hi !== 32'd0) begin
      errors++;
      $display("FAIL pre_reset_hilo: got %h_%h expected 0_%h",
               bus.hi, bus.lo, 32'd7006652);
    end
    bus.start = 1'b1;
    bus.is_div = 1'b0;
    bus.a = $urandom | 32'd1;
    bus.b = $urandom | 32'd1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: got busy %b done %b expected 0 0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      errors++;
      $display("FAIL midrst_hilo: got %h_%h expected 0_0",
               bus.hi, bus.lo);
    end
    tick();
    reset = 1'b0;
    late_done = 0;
    late_busy = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done) late_done++;
      if (bus.busy) late_busy++;
    end
    checks++;
    if (late_done != 0 || late_busy != 0) begin
      errors++;
      $display("FAIL midrst_no_done: done %0d busy %0d expected 0 0",
               late_done, late_busy);
    end
    run_op(1'b1, 32'd100, 32'd7, bc, de, dc, to);
    checks++;
    if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
      errors++;
      $display("FAIL post_rst_div: got %h_%h expected %h_%h",
               bus.hi, bus.lo, 32'd2, 32'd14);
    end
    checks++;
    if (to || de != WIDTH || dc != 1) begin
      errors++;
      $display("FAIL post_rst_timing: edge %0d count %0d expected %0d 1",
               de, dc, WIDTH);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
